sha3_digest_tx_16: RTL and testbench
====================================

SHA3_DIGEST_TX_16 -- requirements
Module: sha3_digest_tx_16

Interface
REQ-001 SHALL have parameter DIGEST_BITS, default 256, digest width in bits; legal values 224, 256, 384, 512.
REQ-002 SHALL have derived constant NWORDS = DIGEST_BITS/16: 14, 16, 24 or 32 beats.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESETn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port d_valid, input, 1, digest is offered by the Keccak core.
REQ-006 SHALL have port d_ready, output, 1, block can accept a digest.
REQ-007 SHALL have port digest, input, DIGEST_BITS, digest with byte k at bits [8k+7:8k].
REQ-008 SHALL have port M_TVALID, output, 1, stream beat valid.
REQ-009 SHALL have port M_TREADY, input, 1, downstream accepts the beat.
REQ-010 SHALL have port M_TDATA, output, 16, beat data; lower byte is the earlier stream byte.
REQ-011 SHALL have port M_TLAST, output, 1, last beat of the digest.
REQ-012 SHALL have port M_TUSER, output, 3, valid byte count on the TLAST beat (2); 0 on all other beats.
REQ-013 SHALL have port busy, output, 1, a digest is being transmitted.

Function
REQ-014 SHALL implement FSM states IDLE and SEND.
REQ-015 SHALL drive d_ready = 1 only in IDLE; busy = 1 only in SEND.
REQ-016 IDLE to SEND SHALL occur on d_valid & d_ready; digest is captured into a shift register on that edge.
REQ-017 SHALL assert M_TVALID in the first cycle after capture with M_TDATA = {byte1, byte0} (one-cycle latency).
REQ-018 Beat n SHALL carry {byte(2n+1), byte(2n)} for n = 0..NWORDS-1.
REQ-019 A beat SHALL complete only on M_TVALID & M_TREADY; on completion the register shifts right by 16 and the beat counter increments.
REQ-020 While M_TVALID = 1 and M_TREADY = 0, M_TDATA, M_TLAST and M_TUSER SHALL hold stable; M_TVALID SHALL NOT deassert.
REQ-021 M_TLAST SHALL be 1 exactly when the counter equals NWORDS-1; M_TUSER SHALL be 3'd2 then, else 3'd0.
REQ-022 The last-beat handshake SHALL return the FSM to IDLE, deassert M_TVALID and raise d_ready on the next cycle; a new digest is never captured in the same cycle.
REQ-023 The beat counter SHALL be $clog2(NWORDS) bits wide, reset to 0 on every capture, and never wrap within a frame.
REQ-024 d_valid and digest SHALL be ignored in SEND; the upstream holds them until d_ready.
REQ-025 Minimum frame spacing SHALL be NWORDS+1 cycles from capture to the next capture, assuming M_TREADY is held high.

Reset
REQ-026 ARESETn low SHALL immediately force IDLE, counter 0, shift register 0, M_TVALID 0, M_TLAST 0, M_TUSER 0, M_TDATA 0, busy 0 and d_ready 1.
REQ-027 A reset during SEND SHALL drop the frame without emitting M_TLAST; the next digest restarts at beat 0.
REQ-028 Reset release SHALL be synchronous to ACLK by the system; the block adds no synchronizer.

Structure
REQ-029 Constants for legal DIGEST_BITS, the M_TUSER full-word code (3'd2) and the FSM state enum SHALL live in the shared sha3_pkg.
REQ-030 SHALL be a single module with no sub-modules; a word counter is inline.
REQ-031 SHALL contain no combinational path from M_TREADY to M_TVALID, M_TDATA or d_ready.

Verification
REQ-032 Basic: DIGEST_BITS=256, digest byte k = k, M_TREADY=1 -> 16 beats 0x0100, 0x0302 … 0x1F1E; TLAST and TUSER=2 on beat 15 only.
REQ-033 Backpressure: M_TREADY low for 3 cycles at beat 5 -> M_TDATA holds 0x0B0A; total beats still 16, no duplicates.
REQ-034 Back-to-back: d_valid held high with 2 digests -> second capture exactly 1 cycle after the first TLAST handshake; d_ready is 0 throughout SEND.
REQ-035 Reset mid-frame: ARESETn low at beat 7 -> M_TVALID is 0 immediately; the next digest starts at beat 0 with word 0x0100.
REQ-036 DIGEST_BITS=224: byte k = 0xA0+k -> 14 beats, last beat 0xBBBA with TLAST=1 and TUSER=2.
REQ-037 Random M_TREADY over 1000 digests: the scoreboard byte stream equals the input digests, with exactly one TLAST per digest.

Source files
------------

// File: rtl/sha3_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sha3_pkg : constants and state encoding for the SHA-3 digest streamers
// Revision : 1.0
// ============================================================================
package sha3_pkg;

  localparam int C_DIGEST_LEGAL [4] = '{224, 256, 384, 512};

  // TUSER byte count carried on a final beat that is a full 16-bit word
  localparam logic [2:0] C_TUSER_FULL = 3'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  function automatic bit is_legal_digest_bits(input int bits);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (C_DIGEST_LEGAL[i] == bits) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha3_digest_tx_16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sha3_digest_tx_16 : serialises a Keccak digest onto a 16-bit AXI-Stream
// Revision          : 1.0
// ============================================================================
module sha3_digest_tx_16
  import sha3_pkg::*;
#(
  parameter int DIGEST_BITS = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   d_valid,
  output logic                   d_ready,
  input  logic [DIGEST_BITS-1:0] digest,
  output logic                   M_TVALID,
  input  logic                   M_TREADY,
  output logic [15:0]            M_TDATA,
  output logic                   M_TLAST,
  output logic [2:0]             M_TUSER,
  output logic                   busy
);

  localparam int NWORDS = DIGEST_BITS / 16;
  localparam int CW     = $clog2(NWORDS);
  localparam logic [CW-1:0] C_LAST_IDX = CW'(NWORDS - 1);

  tx_state_t              r_state;
  logic [DIGEST_BITS-1:0] r_sreg;
  logic [CW-1:0]          r_cnt;
  logic                   r_valid;
  logic                   r_last;
  logic [2:0]             r_user;
  logic                   r_ready;
  logic                   r_busy;
  logic [CW-1:0]          w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 1'b1;

  // Every output is a flop, so M_TREADY only ever reaches register D-inputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_user  <= 3'd0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (d_valid) begin
            r_state <= ST_SEND;
            r_sreg  <= digest;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= (NWORDS == 1);
            r_user  <= (NWORDS == 1) ? C_TUSER_FULL : 3'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (r_valid && M_TREADY) begin
            r_sreg <= r_sreg >> 16;
            if (r_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_user  <= 3'd0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_cnt  <= w_cnt_nxt;
              r_last <= (w_cnt_nxt == C_LAST_IDX);
              r_user <= (w_cnt_nxt == C_LAST_IDX) ? C_TUSER_FULL : 3'd0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign d_ready  = r_ready;
  assign busy     = r_busy;
  assign M_TVALID = r_valid;
  assign M_TDATA  = r_sreg[15:0];
  assign M_TLAST  = r_last;
  assign M_TUSER  = r_user;

endmodule
`default_nettype wire

// File: tb/tb_sha3_digest_tx_16.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench: digests are modelled as byte streams paired into beats.
module tb_sha3_digest_tx_16;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic         ARESETn;
  logic         d_valid;
  logic         d_ready;
  logic [255:0] digest;
  logic         M_TVALID;
  logic         M_TREADY;
  logic [15:0]  M_TDATA;
  logic         M_TLAST;
  logic [2:0]   M_TUSER;
  logic         busy;

  logic         s_dv, s_dr, s_tv, s_tr, s_tl, s_busy;
  logic [223:0] s_dig;
  logic [15:0]  s_td;
  logic [2:0]   s_tu;

  sha3_digest_tx_16 #(.DIGEST_BITS(256)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .d_valid(d_valid), .d_ready(d_ready),
    .digest(digest), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
    .M_TDATA(M_TDATA), .M_TLAST(M_TLAST), .M_TUSER(M_TUSER), .busy(busy)
  );

  sha3_digest_tx_16 #(.DIGEST_BITS(224)) dut224 (
    .ACLK(ACLK), .ARESETn(ARESETn), .d_valid(s_dv), .d_ready(s_dr),
    .digest(s_dig), .M_TVALID(s_tv), .M_TREADY(s_tr),
    .M_TDATA(s_td), .M_TLAST(s_tl), .M_TUSER(s_tu), .busy(s_busy)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [2:0]  user;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    cap_count = 0;
  int    tlast_count = 0;
  int    last_tlast_cyc = -100;
  int    beat_idx = 0;
  int    rdy_mode = 0;
  int    stall_cnt = 0;
  bit    in_frame = 1'b0;
  bit    b2b_arm = 1'b0;
  bit    done224 = 1'b0;

  always @(posedge ACLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: digest byte k goes out k-th; bytes pair into little-endian words.
  function automatic void push_frame(input logic [255:0] d, input int nbytes);
    logic [7:0] b [32];
    beat_t      e;
    for (int k = 0; k < nbytes; k++) b[k] = d[8*k +: 8];
    for (int n = 0; n < nbytes / 2; n++) begin
      e.data = {b[2*n+1], b[2*n]};
      e.last = (n == nbytes / 2 - 1);
      e.user = e.last ? 3'd2 : 3'd0;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor and capture watcher, sampled mid-cycle.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      check("d_ready", {31'd0, d_ready}, {31'd0, !in_frame});
      check("busy", {31'd0, busy}, {31'd0, in_frame});
      check("tvalid", {31'd0, M_TVALID}, {31'd0, in_frame});
      if (rdy_mode == 2 && M_TVALID && !M_TREADY)
        check("bp_hold", {16'd0, M_TDATA}, 32'h0B0A);
      if (M_TVALID) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got 0x%0h expected none", M_TDATA);
        end else begin
          check("tdata", {16'd0, M_TDATA}, {16'd0, exp_q[0].data});
          check("tlast", {31'd0, M_TLAST}, {31'd0, exp_q[0].last});
          check("tuser", {29'd0, M_TUSER}, {29'd0, exp_q[0].user});
          if (M_TREADY) begin
            beat_idx++;
            if (exp_q[0].last) begin
              in_frame = 1'b0;
              beat_idx = 0;
              last_tlast_cyc = cyc;
              tlast_count++;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      if (d_valid && d_ready) begin
        if (b2b_arm) check("b2b_gap", cyc - last_tlast_cyc, 32'd1);
        push_frame(digest, 32);
        in_frame = 1'b1;
        beat_idx = 0;
        cap_count++;
      end
    end
  end

  initial begin
    M_TREADY = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      case (rdy_mode)
        1: M_TREADY = ($urandom_range(0, 3) != 0);
        2: begin
          if (in_frame && beat_idx == 5 && stall_cnt < 3) begin
            M_TREADY = 1'b0;
            stall_cnt++;
          end else begin
            M_TREADY = 1'b1;
          end
        end
        default: M_TREADY = 1'b1;
      endcase
    end
  end

  task automatic offer(input logic [255:0] d, input bit keep);
    int c0;
    c0 = cap_count;
    digest  = d;
    d_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge ACLK);
      #2;
      if (cap_count != c0) break;
    end
    if (cap_count == c0) begin
      checks++; errors++;
      $display("FAIL capture_timeout: got no capture expected one");
    end
    if (!keep) d_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && !in_frame) break;
      @(posedge ACLK);
      #2;
    end
    if (i == 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got %0d pending beats expected 0", exp_q.size());
    end
  endtask

  function automatic logic [255:0] ramp(input logic [7:0] base);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) d[8*k +: 8] = base + 8'(k);
    return d;
  endfunction

  // 224-bit instance: byte k = 0xA0+k, 14 beats.
  initial begin
    int n;
    s_dv  = 1'b0;
    s_tr  = 1'b1;
    for (int k = 0; k < 28; k++) s_dig[8*k +: 8] = 8'hA0 + 8'(k);
    @(posedge ARESETn);
    @(posedge ACLK);
    #2;
    s_dv = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 14; i++) begin
      @(negedge ACLK);
      if (s_busy) s_dv = 1'b0;
      if (s_tv && s_tr) begin
        check("d224_data", {16'd0, s_td},
              {16'd0, 8'hA0 + 8'(2*n+1), 8'hA0 + 8'(2*n)});
        check("d224_last", {31'd0, s_tl}, {31'd0, (n == 13)});
        check("d224_user", {29'd0, s_tu}, (n == 13) ? 32'd2 : 32'd0);
        n++;
      end
    end
    check("d224_beats", n, 32'd14);
    @(negedge ACLK);
    check("d224_idle", {30'd0, s_tv, s_dr}, 32'd1);
    done224 = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [255:0] d;
    int           frames;
    ARESETn = 1'b0;
    d_valid = 1'b0;
    digest  = '0;
    repeat (2) @(posedge ACLK);
    #2;
    check("rst_outputs", {M_TVALID, M_TLAST, busy, d_ready, M_TUSER, M_TDATA},
          {4'b0001, 3'd0, 16'h0000});
    ARESETn = 1'b1;

    // Basic ramp frame
    rdy_mode = 0;
    offer(ramp(8'h00), 1'b0);
    wait_idle();
    check("basic_frames", tlast_count, 32'd1);

    // Backpressure at beat 5
    rdy_mode  = 2;
    stall_cnt = 0;
    offer(ramp(8'h00), 1'b0);
    wait_idle();
    check("bp_stalls", stall_cnt, 32'd3);
    rdy_mode = 0;

    // Back-to-back with d_valid held high
    offer(ramp(8'h40), 1'b1);
    b2b_arm = 1'b1;
    offer(ramp(8'h80), 1'b0);
    b2b_arm = 1'b0;
    wait_idle();

    wait (done224);

    // Reset in the middle of a frame
    offer(ramp(8'hC0), 1'b0);
    for (int i = 0; i < 100 && beat_idx != 7; i++) begin
      @(posedge ACLK);
      #2;
    end
    check("rst_beat_reached", beat_idx, 32'd7);
    ARESETn = 1'b0;
    #1;
    check("rst_mid_outputs", {M_TVALID, M_TLAST, busy, d_ready, M_TUSER, M_TDATA},
          {4'b0001, 3'd0, 16'h0000});
    exp_q.delete();
    in_frame = 1'b0;
    beat_idx = 0;
    repeat (2) @(posedge ACLK);
    #2;
    ARESETn = 1'b1;
    offer(ramp(8'h00), 1'b0);
    wait_idle();

    // Random digests under random backpressure
    rdy_mode    = 1;
    tlast_count = 0;
    frames      = 0;
    for (int f = 0; f < 1000; f++) begin
      for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom();
      offer(d, 1'b0);
      frames++;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge ACLK);
    end
    wait_idle();
    check("rand_frames", tlast_count, frames);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
